// File: rtl/reset_sequencer.sv
// reset_sequencer: holds all downstream reset domains for HOLD_CYCLES after a
// trigger, then releases them one by one (bit 0 first) every STAGE_GAP cycles.
// Triggers are RST, a software request, or a watchdog timeout in RUN; the cause
// of the most recent sequence is kept in rst_cause.
module reset_sequencer #(
   parameter int NUM_DOM     = 4,
   parameter int HOLD_CYCLES = 128,
   parameter int STAGE_GAP   = 16,
   parameter int CNT_W       = 16,
   parameter int WDT_TIMEOUT = 1 << 20,
   parameter int WDT_W       = 24
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               sw_rst_req,
   input  logic               wdt_enable,
   input  logic               wdt_kick,
   output logic [NUM_DOM-1:0] rst_out,
   output logic               all_released,
   output logic               busy,
   output logic [1:0]         rst_cause
);

   localparam int IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
   localparam logic [WDT_W-1:0] WDT_LAST  = WDT_W'(WDT_TIMEOUT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DOM - 1);

   localparam logic [1:0] CAUSE_RST = 2'b00;
   localparam logic [1:0] CAUSE_SW  = 2'b01;
   localparam logic [1:0] CAUSE_WDT = 2'b10;

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_RELEASE = 2'd1,
      ST_RUN     = 2'd2
   } state_t;

   state_t             state, state_d;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic [IDX_W-1:0]   idx, idx_d;
   logic [WDT_W-1:0]   wdt_cnt, wdt_cnt_d;
   logic [NUM_DOM-1:0] rst_out_d;
   logic               all_released_d;
   logic               busy_d;
   logic [1:0]         rst_cause_d;
   logic               wdt_timeout;

   // Next-state and registered-output computation; triggers override the
   // normal sequencing so a restart always begins from a clean hold phase.
   always_comb begin
      state_d        = state;
      cnt_d          = cnt;
      idx_d          = idx;
      wdt_cnt_d      = wdt_cnt;
      rst_out_d      = rst_out;
      all_released_d = all_released;
      busy_d         = busy;
      rst_cause_d    = rst_cause;
      wdt_timeout    = 1'b0;

      case (state)
         ST_ASSERT: begin
            wdt_cnt_d = '0;
            if (cnt == HOLD_LAST) begin
               rst_out_d[0] = 1'b0;
               if (NUM_DOM == 1) begin
                  state_d        = ST_RUN;
                  all_released_d = 1'b1;
                  busy_d         = 1'b0;
               end else begin
                  state_d = ST_RELEASE;
                  cnt_d   = '0;
                  idx_d   = IDX_W'(1);
               end
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end

         ST_RELEASE: begin
            wdt_cnt_d = '0;
            if (cnt == GAP_LAST) begin
               rst_out_d[idx] = 1'b0;
               cnt_d          = '0;
               idx_d          = idx + IDX_W'(1);
               if (idx == IDX_LAST) begin
                  state_d        = ST_RUN;
                  all_released_d = 1'b1;
                  busy_d         = 1'b0;
               end
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end

         ST_RUN: begin
            // A kick or a disabled watchdog clears the count before any
            // timeout test, so a kick on the timeout edge suppresses it.
            if (!wdt_enable || wdt_kick) begin
               wdt_cnt_d = '0;
            end else if (wdt_cnt == WDT_LAST) begin
               wdt_timeout = 1'b1;
            end else begin
               wdt_cnt_d = wdt_cnt + WDT_W'(1);
            end
         end

         default: begin
            state_d = ST_ASSERT;
         end
      endcase

      // Software request outranks the watchdog when both land on one edge.
      if (sw_rst_req || wdt_timeout) begin
         state_d        = ST_ASSERT;
         cnt_d          = '0;
         idx_d          = '0;
         wdt_cnt_d      = '0;
         rst_out_d      = '1;
         all_released_d = 1'b0;
         busy_d         = 1'b1;
         rst_cause_d    = sw_rst_req ? CAUSE_SW : CAUSE_WDT;
      end
   end

   // State and output registers; RST forces the power-up trigger state.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= ST_ASSERT;
         cnt          <= '0;
         idx          <= '0;
         wdt_cnt      <= '0;
         rst_out      <= '1;
         all_released <= 1'b0;
         busy         <= 1'b1;
         rst_cause    <= CAUSE_RST;
      end else begin
         state        <= state_d;
         cnt          <= cnt_d;
         idx          <= idx_d;
         wdt_cnt      <= wdt_cnt_d;
         rst_out      <= rst_out_d;
         all_released <= all_released_d;
         busy         <= busy_d;
         rst_cause    <= rst_cause_d;
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scenarios for reset_sequencer with an
// edge-indexed scoreboard of expected output snapshots.
module tb_reset_sequencer;

   logic       CLK = 1'b0;
   logic       RST;
   logic       sw_rst_req;
   logic       wdt_enable;
   logic       wdt_kick;
   logic [3:0] rst_out;
   logic       all_released;
   logic       busy;
   logic [1:0] rst_cause;

   reset_sequencer #(
      .NUM_DOM    (4),
      .HOLD_CYCLES(8),
      .STAGE_GAP  (4),
      .CNT_W      (16),
      .WDT_TIMEOUT(32),
      .WDT_W      (24)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .sw_rst_req  (sw_rst_req),
      .wdt_enable  (wdt_enable),
      .wdt_kick    (wdt_kick),
      .rst_out     (rst_out),
      .all_released(all_released),
      .busy        (busy),
      .rst_cause   (rst_cause)
   );

   always #5 CLK = ~CLK;

   // Number of rising edges seen so far; read only on falling edges.
   int edge_n = 0;
   always @(posedge CLK) edge_n <= edge_n + 1;

   typedef struct {
      int         cyc;
      logic [3:0] ro;
      logic       ar;
      logic       b;
      logic [1:0] c;
      string      tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   bit   stim_done = 1'b0;

   task automatic push(input int cyc, input logic [3:0] ro, input logic ar,
                       input logic b, input logic [1:0] c, input string tag);
      exp_t e;
      e.cyc = cyc; e.ro = ro; e.ar = ar; e.b = b; e.c = c; e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic push_run(input int from, input int to, input logic [1:0] c);
      for (int i = from; i <= to; i += 8) push(i, 4'b0000, 1'b1, 1'b0, c, "run_hold");
   endtask

   task automatic wait_edge(input int n);
      while (edge_n < n) @(negedge CLK);
   endtask

   // Monitor: compares the outputs registered at each edge with any
   // expectation scheduled for that edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         while (exp_q.size() > 0 && exp_q[0].cyc <= edge_n) begin
            e = exp_q.pop_front();
            n_tests++;
            if (e.cyc != edge_n || rst_out !== e.ro || all_released !== e.ar ||
                busy !== e.b || rst_cause !== e.c) begin
               n_fail++;
               $display("FAIL %s @edge %0d (sampled at %0d): got rst_out=%b all_released=%b busy=%b rst_cause=%b, expected %b %b %b %b",
                        e.tag, e.cyc, edge_n, rst_out, all_released, busy, rst_cause,
                        e.ro, e.ar, e.b, e.c);
            end
         end
         if (stim_done) begin
            while (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               n_tests++;
               n_fail++;
               $display("FAIL %s @edge %0d: never sampled, expected rst_out=%b", e.tag, e.cyc, e.ro);
            end
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
         end
      end
   end

   // Stimulus: directed scenarios with hand-computed expectation edges.
   initial begin
      RST = 1'b1; sw_rst_req = 1'b0; wdt_enable = 1'b0; wdt_kick = 1'b0;

      // Power-up: RST high through edge 3.
      push(1,  4'b1111, 1'b0, 1'b1, 2'b00, "reset_state");
      push(10, 4'b1111, 1'b0, 1'b1, 2'b00, "pu_hold_end");
      push(11, 4'b1110, 1'b0, 1'b1, 2'b00, "pu_bit0");
      push(14, 4'b1110, 1'b0, 1'b1, 2'b00, "pu_gap");
      push(15, 4'b1100, 1'b0, 1'b1, 2'b00, "pu_bit1");
      push(19, 4'b1000, 1'b0, 1'b1, 2'b00, "pu_bit2");
      push(22, 4'b1000, 1'b0, 1'b1, 2'b00, "pu_pre_run");
      push(23, 4'b0000, 1'b1, 1'b0, 2'b00, "pu_run");
      wait_edge(3);
      RST = 1'b0;

      // Software reset at edge 30.
      push(29, 4'b0000, 1'b1, 1'b0, 2'b00, "sw_before");
      push(30, 4'b1111, 1'b0, 1'b1, 2'b01, "sw_trigger");
      push(37, 4'b1111, 1'b0, 1'b1, 2'b01, "sw_hold_end");
      push(38, 4'b1110, 1'b0, 1'b1, 2'b01, "sw_bit0");
      push(42, 4'b1100, 1'b0, 1'b1, 2'b01, "sw_bit1");
      push(46, 4'b1000, 1'b0, 1'b1, 2'b01, "sw_bit2");
      push(50, 4'b0000, 1'b1, 1'b0, 2'b01, "sw_run");
      wait_edge(29); sw_rst_req = 1'b1;
      wait_edge(30); sw_rst_req = 1'b0;

      // Watchdog disabled for 1000 cycles: stays in RUN.
      push_run(51, 1050, 2'b01);
      wait_edge(1050);
      wdt_enable = 1'b1;

      // Kicks every 16 cycles (edges 1051..2043), then no kicks.
      push_run(1051, 2072, 2'b01);
      push(2074, 4'b0000, 1'b1, 1'b0, 2'b01, "wdt_before");
      push(2075, 4'b1111, 1'b0, 1'b1, 2'b10, "wdt_trigger");
      push(2083, 4'b1110, 1'b0, 1'b1, 2'b10, "wdt_bit0");
      push(2087, 4'b1100, 1'b0, 1'b1, 2'b10, "wdt_bit1");
      push(2091, 4'b1000, 1'b0, 1'b1, 2'b10, "wdt_bit2");
      push(2095, 4'b0000, 1'b1, 1'b0, 2'b10, "wdt_run");
      push(2126, 4'b0000, 1'b1, 1'b0, 2'b10, "kick_before");
      push(2127, 4'b0000, 1'b1, 1'b0, 2'b10, "kick_on_timeout");
      push(2158, 4'b0000, 1'b1, 1'b0, 2'b10, "kick_next_before");
      push(2159, 4'b1111, 1'b0, 1'b1, 2'b01, "sw_on_timeout");
      for (int k = 0; k < 63; k++) begin
         wait_edge(1050 + 16 * k); wdt_kick = 1'b1;
         wait_edge(1051 + 16 * k); wdt_kick = 1'b0;
      end

      // Kick coincident with the timeout at edge 2127.
      wait_edge(2126); wdt_kick = 1'b1;
      wait_edge(2127); wdt_kick = 1'b0;

      // Software request coincident with the timeout at edge 2159.
      wait_edge(2158); sw_rst_req = 1'b1;
      wait_edge(2159); sw_rst_req = 1'b0;

      // Restart mid-RELEASE at 2172, then watchdog, then RST mid-RELEASE.
      push(2167, 4'b1110, 1'b0, 1'b1, 2'b01, "rs_bit0");
      push(2171, 4'b1100, 1'b0, 1'b1, 2'b01, "rs_bit1");
      push(2172, 4'b1111, 1'b0, 1'b1, 2'b01, "rs_restart");
      push(2179, 4'b1111, 1'b0, 1'b1, 2'b01, "rs_no_early");
      push(2180, 4'b1110, 1'b0, 1'b1, 2'b01, "rs_bit0_new");
      push(2184, 4'b1100, 1'b0, 1'b1, 2'b01, "rs_bit1_new");
      push(2188, 4'b1000, 1'b0, 1'b1, 2'b01, "rs_bit2_new");
      push(2192, 4'b0000, 1'b1, 1'b0, 2'b01, "rs_run");
      push(2223, 4'b0000, 1'b1, 1'b0, 2'b01, "wdt2_before");
      push(2224, 4'b1111, 1'b0, 1'b1, 2'b10, "wdt2_trigger");
      push(2232, 4'b1110, 1'b0, 1'b1, 2'b10, "wdt2_bit0");
      push(2236, 4'b1100, 1'b0, 1'b1, 2'b10, "wdt2_bit1");
      push(2237, 4'b1100, 1'b0, 1'b1, 2'b10, "rst_before");
      push(2238, 4'b1111, 1'b0, 1'b1, 2'b00, "rst_mid_release");
      push(2239, 4'b1111, 1'b0, 1'b1, 2'b00, "rst_last_high");
      push(2246, 4'b1111, 1'b0, 1'b1, 2'b00, "rst_hold_end");
      push(2247, 4'b1110, 1'b0, 1'b1, 2'b00, "rst_bit0");
      push(2251, 4'b1100, 1'b0, 1'b1, 2'b00, "rst_bit1");
      push(2255, 4'b1000, 1'b0, 1'b1, 2'b00, "rst_bit2");
      push(2258, 4'b1000, 1'b0, 1'b1, 2'b00, "rst_pre_run");
      push(2259, 4'b0000, 1'b1, 1'b0, 2'b00, "rst_run");
      push(2268, 4'b0000, 1'b1, 1'b0, 2'b00, "rst_run_hold");
      wait_edge(2171); sw_rst_req = 1'b1;
      wait_edge(2172); sw_rst_req = 1'b0;
      wait_edge(2237); RST = 1'b1;
      wait_edge(2239); RST = 1'b0;

      wait_edge(2270);
      stim_done = 1'b1;
   end

   // Hard stop in case the monitor never reaches its summary.
   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, edge=%0d", edge_n);
      $fatal(1, "timeout");
   end

endmodule
